// File: rtl/counter_checker.sv
// Passive checker for a loadable up-counter: predicts each cycle's count from the
// previous cycle's observed inputs, flags mismatches and keeps a saturating error tally.
module counter_checker #(
    parameter int WIDTH     = 8,
    parameter int ERR_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 chk_en,
    input  logic                 cen,
    input  logic                 wen,
    input  logic [WIDTH-1:0]     dat,
    input  logic [WIDTH-1:0]     cnt,
    input  logic                 clr,
    output logic [WIDTH-1:0]     exp_val,
    output logic                 mismatch,
    output logic                 err_flag,
    output logic [ERR_WIDTH-1:0] err_cnt,
    output logic                 locked
);

    // state  | meaning
    // UNSYNC | no valid baseline sample yet
    // TRACK  | locked, last compare passed
    // FAULT  | last compare failed
    typedef enum logic [1:0] {
        UNSYNC = 2'd0,
        TRACK  = 2'd1,
        FAULT  = 2'd2
    } state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     p_cnt_q;
    logic                 p_cen_q;
    logic                 p_wen_q;
    logic [WIDTH-1:0]     p_dat_q;
    logic                 mismatch_q;
    logic                 err_flag_q;
    logic [ERR_WIDTH-1:0] err_cnt_q;
    logic                 locked_q;

    logic                 miss;
    logic                 err_flag_d;
    logic [ERR_WIDTH-1:0] err_cnt_d;

    assign exp_val = p_wen_q ? p_dat_q : (p_cnt_q + {{(WIDTH-1){1'b0}}, p_cen_q});

    always_comb begin
        miss       = 1'b0;
        err_flag_d = err_flag_q;
        err_cnt_d  = err_cnt_q;
        if (chk_en && (state_q != UNSYNC)) begin
            miss = (exp_val != cnt);
        end
        // A miss in the same cycle as clr wins: the error is still recorded.
        if (miss) begin
            err_flag_d = 1'b1;
            if (clr) begin
                err_cnt_d = ERR_WIDTH'(1);
            end else if (err_cnt_q != {ERR_WIDTH{1'b1}}) begin
                err_cnt_d = err_cnt_q + ERR_WIDTH'(1);
            end
        end else if (clr) begin
            err_flag_d = 1'b0;
            err_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= UNSYNC;
            p_cnt_q    <= '0;
            p_cen_q    <= 1'b0;
            p_wen_q    <= 1'b0;
            p_dat_q    <= '0;
            mismatch_q <= 1'b0;
            err_flag_q <= 1'b0;
            err_cnt_q  <= '0;
            locked_q   <= 1'b0;
        end else begin
            err_flag_q <= err_flag_d;
            err_cnt_q  <= err_cnt_d;
            if (!chk_en) begin
                state_q    <= UNSYNC;
                mismatch_q <= 1'b0;
                locked_q   <= 1'b0;
            end else begin
                // Baseline always follows the observed count, so a single bad value
                // yields exactly one miss.
                p_cnt_q <= cnt;
                p_cen_q <= cen;
                p_wen_q <= wen;
                p_dat_q <= dat;
                case (state_q)
                    UNSYNC: begin
                        state_q    <= TRACK;
                        mismatch_q <= 1'b0;
                        locked_q   <= 1'b1;
                    end
                    default: begin
                        state_q    <= miss ? FAULT : TRACK;
                        mismatch_q <= miss;
                        locked_q   <= !miss;
                    end
                endcase
            end
        end
    end

    assign mismatch = mismatch_q;
    assign err_flag = err_flag_q;
    assign err_cnt  = err_cnt_q;
    assign locked   = locked_q;

endmodule

// File: tb/tb_counter_checker.sv
// Self-checking bench for counter_checker: directed scenarios plus random traffic,
// compared against a cycle-level reference model of the counter contract.
module tb_counter_checker;

    logic       clk = 1'b0;
    logic       rst, chk_en, cen, wen, clr;
    logic [7:0] dat, cnt;
    logic [7:0] exp_val;
    logic       mismatch, err_flag, locked;
    logic [3:0] err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: last accepted observation and expected outputs.
    bit m_valid;
    int m_pcnt, m_pcen, m_pwen, m_pdat;
    bit m_mis, m_lock, m_flag;
    int m_ecnt;

    counter_checker #(.WIDTH(8), .ERR_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .chk_en(chk_en), .cen(cen), .wen(wen),
        .dat(dat), .cnt(cnt), .clr(clr), .exp_val(exp_val),
        .mismatch(mismatch), .err_flag(err_flag), .err_cnt(err_cnt), .locked(locked)
    );

    always #5 clk = ~clk;

    function automatic int predict();
        return (m_pwen != 0) ? m_pdat : (m_pcnt + m_pcen) % 256;
    endfunction

    task automatic cycle(input bit r, input bit ce, input bit c, input bit w,
                         input bit [7:0] d, input bit [7:0] q, input bit cl);
        bit miss;
        rst = r; chk_en = ce; cen = c; wen = w; dat = d; cnt = q; clr = cl;
        @(posedge clk);
        miss = 1'b0;
        if (r) begin
            m_valid = 0; m_pcnt = 0; m_pcen = 0; m_pwen = 0; m_pdat = 0;
            m_mis = 0; m_lock = 0; m_flag = 0; m_ecnt = 0;
        end else begin
            if (ce && m_valid) miss = (int'(q) != predict());
            if (miss) m_flag = 1; else if (cl) m_flag = 0;
            if (miss) m_ecnt = cl ? 1 : ((m_ecnt < 15) ? m_ecnt + 1 : 15);
            else if (cl) m_ecnt = 0;
            m_mis  = miss;
            m_lock = ce && !miss;
            if (ce) begin
                m_pcnt = q; m_pcen = c; m_pwen = w; m_pdat = d;
            end
            m_valid = ce;
        end
        #1;
    endtask

    task automatic test_reset();
        cycle(1, 0, 0, 0, 8'h00, 8'h00, 0);
        cycle(1, 1, 1, 1, 8'hA5, 8'h77, 1);
        n_checks++;
        if ({exp_val, mismatch, err_flag, err_cnt, locked} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset: exp=%h mis=%b flag=%b ecnt=%0d lock=%b, required all 0",
                     exp_val, mismatch, err_flag, err_cnt, locked);
        end
    endtask

    task automatic test_free_count();
        bit [7:0] q = 8'hF0;
        cycle(1, 0, 0, 0, 8'h00, 8'h00, 0);
        for (int i = 0; i < 40; i++) begin
            cycle(0, 1, 1, 0, 8'($urandom), q, 0);
            q = q + 8'd1;
            n_checks++;
            if (mismatch !== 1'b0 || locked !== 1'b1 || err_cnt !== 4'd0 ||
                exp_val !== 8'(predict())) begin
                n_fail++;
                $display("FAIL free_count[%0d]: mis=%b lock=%b ecnt=%0d exp=%h, required 0 1 0 %h",
                         i, mismatch, locked, err_cnt, exp_val, predict());
            end
        end
    endtask

    task automatic test_load();
        cycle(0, 1, 1, 1, 8'h5A, 8'h30, 0);
        cycle(0, 1, 1, 0, 8'h00, 8'h5A, 0);
        n_checks++;
        if (mismatch !== 1'b0 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL load_pass: mis=%b lock=%b, required 0 1", mismatch, locked);
        end
        cycle(0, 1, 0, 1, 8'h5A, 8'h5B, 0);
        cycle(0, 1, 1, 0, 8'h00, 8'h00, 0);
        n_checks++;
        if (mismatch !== 1'b1 || locked !== 1'b0 || err_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL load_miss: mis=%b lock=%b flag=%b, required 1 0 1",
                     mismatch, locked, err_flag);
        end
    endtask

    task automatic test_single_fault();
        cycle(1, 0, 0, 0, 8'h00, 8'h00, 0);
        cycle(0, 1, 1, 0, 8'h00, 8'h10, 0);
        cycle(0, 1, 1, 0, 8'h00, 8'h11, 0);
        cycle(0, 1, 1, 0, 8'h00, 8'h20, 0);
        n_checks++;
        if (mismatch !== 1'b1 || err_flag !== 1'b1 || err_cnt !== 4'd1 || locked !== 1'b0) begin
            n_fail++;
            $display("FAIL single_fault: mis=%b flag=%b ecnt=%0d lock=%b, required 1 1 1 0",
                     mismatch, err_flag, err_cnt, locked);
        end
        cycle(0, 1, 1, 0, 8'h00, 8'h21, 0);
        n_checks++;
        if (mismatch !== 1'b0 || err_cnt !== 4'd1 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL single_resync: mis=%b ecnt=%0d lock=%b, required 0 1 1",
                     mismatch, err_cnt, locked);
        end
    endtask

    task automatic test_stuck();
        cycle(1, 0, 0, 0, 8'h00, 8'h00, 0);
        cycle(0, 1, 1, 0, 8'h00, 8'h33, 0);
        for (int i = 0; i < 20; i++) begin
            cycle(0, 1, 1, 0, 8'h00, 8'h33, 0);
            n_checks++;
            if (mismatch !== 1'b1 || err_cnt !== 4'(m_ecnt) || locked !== 1'b0) begin
                n_fail++;
                $display("FAIL stuck[%0d]: mis=%b ecnt=%0d lock=%b, required 1 %0d 0",
                         i, mismatch, err_cnt, locked, m_ecnt);
            end
        end
        n_checks++;
        if (err_cnt !== 4'd15) begin
            n_fail++;
            $display("FAIL stuck_sat: ecnt=%0d, required 15", err_cnt);
        end
    endtask

    task automatic test_clr_race();
        cycle(0, 1, 1, 0, 8'h00, 8'h33, 1);
        n_checks++;
        if (err_flag !== 1'b1 || err_cnt !== 4'd1 || mismatch !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_race: flag=%b ecnt=%0d mis=%b, required 1 1 1",
                     err_flag, err_cnt, mismatch);
        end
        cycle(0, 1, 1, 0, 8'h00, 8'h34, 1);
        n_checks++;
        if (err_flag !== 1'b0 || err_cnt !== 4'd0 || mismatch !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_alone: flag=%b ecnt=%0d mis=%b, required 0 0 0",
                     err_flag, err_cnt, mismatch);
        end
    endtask

    task automatic test_enable();
        for (int i = 0; i < 6; i++) begin
            cycle(0, 0, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 0);
            n_checks++;
            if (mismatch !== 1'b0 || locked !== 1'b0) begin
                n_fail++;
                $display("FAIL disabled[%0d]: mis=%b lock=%b, required 0 0", i, mismatch, locked);
            end
        end
        cycle(0, 1, 1, 0, 8'h00, 8'hC7, 0);
        n_checks++;
        if (mismatch !== 1'b0 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL reenable: mis=%b lock=%b, required 0 1", mismatch, locked);
        end
        cycle(0, 1, 1, 0, 8'h00, 8'hC8, 0);
        n_checks++;
        if (mismatch !== 1'b0 || locked !== 1'b1 || exp_val !== 8'hC9) begin
            n_fail++;
            $display("FAIL reenable_track: mis=%b lock=%b exp=%h, required 0 1 c9",
                     mismatch, locked, exp_val);
        end
    endtask

    task automatic test_reset_mid_fault();
        cycle(0, 1, 1, 0, 8'h00, 8'h00, 0);
        n_checks++;
        if (mismatch !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_fault: mis=%b, required 1", mismatch);
        end
        cycle(1, 1, 1, 0, 8'h00, 8'h44, 0);
        n_checks++;
        if ({exp_val, mismatch, err_flag, err_cnt, locked} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_mid_fault: exp=%h mis=%b flag=%b ecnt=%0d lock=%b, required all 0",
                     exp_val, mismatch, err_flag, err_cnt, locked);
        end
    endtask

    task automatic test_random();
        bit [7:0] q = 8'($urandom);
        bit       r, ce, c, w, cl;
        bit [7:0] d, drv;
        for (int i = 0; i < 400; i++) begin
            r   = ($urandom_range(99) < 2);
            ce  = ($urandom_range(99) < 90);
            c   = 1'($urandom);
            w   = ($urandom_range(99) < 15);
            cl  = ($urandom_range(99) < 5);
            d   = 8'($urandom);
            drv = ($urandom_range(99) < 6) ? 8'($urandom) : q;
            cycle(r, ce, c, w, d, drv, cl);
            q = w ? d : drv + 8'(c);
            n_checks++;
            if (mismatch !== m_mis || locked !== m_lock || err_flag !== m_flag ||
                err_cnt !== 4'(m_ecnt) || exp_val !== 8'(predict())) begin
                n_fail++;
                $display("FAIL random[%0d]: mis=%b lock=%b flag=%b ecnt=%0d exp=%h, required %b %b %b %0d %h",
                         i, mismatch, locked, err_flag, err_cnt, exp_val,
                         m_mis, m_lock, m_flag, m_ecnt, predict());
            end
        end
    endtask

    initial begin
        rst = 1'b1; chk_en = 1'b0; cen = 1'b0; wen = 1'b0; clr = 1'b0;
        dat = 8'h00; cnt = 8'h00;
        test_reset();
        test_free_count();
        test_load();
        test_single_fault();
        test_stuck();
        test_clr_race();
        test_enable();
        test_reset_mid_fault();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_checker.md
Name: counter_checker

Overview:
- Passive checker that sits on the other end of the loadable up-counter's interface. It observes the counter's control inputs (cen, wen, dat) and its posedge output value on the same clock.
- Each cycle it predicts the next counter value and compares it against the observed value. It reports mismatches, keeps a sticky error flag and a saturating error count, and exposes its lock state.
- Instantiated beside each counter in simulation and FPGA self-check builds.

Parameters:
- WIDTH, 8, width of counter value and load data
- ERR_WIDTH, 4, width of saturating error counter

Ports:
- clk  input  1  system clock; all logic on posedge
- rst  input  1  reset, synchronous, active-high
- chk_en  input  1  checking enable; 0 forces UNSYNC
- cen  input  1  counter enable as presented to the counter
- wen  input  1  counter write enable as presented to the counter
- dat  input  WIDTH  counter load data
- cnt  input  WIDTH  observed counter output (posedge copy)
- clr  input  1  clears err_flag and err_cnt
- exp_val  output  WIDTH  predicted value of cnt for the current cycle
- mismatch  output  1  registered one-cycle pulse per detected mismatch
- err_flag  output  1  sticky error flag
- err_cnt  output  ERR_WIDTH  saturating mismatch count
- locked  output  1  high while state is TRACK

Behaviour:
- Interface is one clock (clk), synchronous active-high reset (rst).
- Counter model: at posedge k, cnt(k+1) = wen(k) ? dat(k) : cnt(k) + cen(k), modulo 2^WIDTH, with wrap-around 0xFF+1 -> 0x00 for WIDTH=8.
- Sample registers, updated every posedge when chk_en=1: p_cnt<=cnt, p_cen<=cen, p_wen<=wen, p_dat<=dat.
- exp_val is combinational from the sample registers: p_wen ? p_dat : p_cnt + {0,p_cen}, truncated to WIDTH.
- wen has priority over cen; cen is ignored when wen=1.
- Compare: hit = (exp_val == cnt), evaluated only in TRACK or FAULT.
- States:
  - UNSYNC: no valid baseline.
  - TRACK: locked, last compare passed.
  - FAULT: last compare failed.
- Transitions, evaluated at each posedge, in priority order:
  - rst=1 -> UNSYNC.
  - chk_en=0 -> UNSYNC. Sample registers hold; no compare; no mismatch.
  - UNSYNC with chk_en=1 -> TRACK. Only the samples are captured this cycle; no compare is made.
  - TRACK or FAULT: hit -> TRACK; miss -> FAULT.
- Resynchronisation: the baseline always comes from the observed cnt. One miss therefore produces exactly one mismatch, and checking resumes against the faulty value on the next cycle. A persistent fault, such as a stuck counter with cen=1, gives a miss every cycle.
- mismatch: registered. It is 1 for the cycle after the posedge at which a miss was evaluated, and 0 otherwise.
- err_flag:
  - Set on a miss.
  - Cleared by clr.
  - Miss and clr in the same cycle -> err_flag=1 (set wins).
- err_cnt:
  - +1 per miss, saturating at 2^ERR_WIDTH-1.
  - clr resets it to 0.
  - Miss and clr in the same cycle -> err_cnt=1.
- locked = (state==TRACK), registered.
- Reset values: state UNSYNC, samples 0, exp_val 0, mismatch 0, err_flag 0, err_cnt 0, locked 0.
- Reset mid-operation: there is no compare on the reset cycle. The first compare happens 2 posedges after rst falls, provided chk_en=1.
- Latency:
  - Deassertion of rst or assertion of chk_en -> locked=1 after 1 posedge.
  - Faulty cnt -> mismatch=1 one cycle after that cnt is sampled.

Test Plan:
- Free count. WIDTH=8, rst then chk_en=1, cen=1, wen=0, cnt 0x00,0x01,0x02... -> locked=1 from cycle 2; mismatch never 1; err_cnt=0.
- Wrap and load.
  - cnt=0xFF with cen=1 -> next cnt 0x00 passes.
  - wen=1, dat=0x5A, cen=1 -> next cnt 0x5A passes; 0x00 would flag.
- Single fault. Counting 0x10,0x11, then injected 0x20 -> one mismatch pulse, err_flag=1, err_cnt=1, locked=0 for one cycle. Next 0x21 -> locked=1, no further mismatch.
- Stuck counter. cnt held at 0x33 with cen=1 for 20 cycles -> mismatch every cycle; err_cnt saturates at 15 and stays there.
- clr race. Set clr=1 in the same cycle as a miss -> err_flag=1, err_cnt=1. Then clr alone -> err_flag=0, err_cnt=0.
- Enable and reset.
  - chk_en=0 with garbage cnt -> no mismatch, locked=0. Re-enable -> locked after 1 cycle, with no false miss.
  - rst mid-FAULT -> all outputs 0, state UNSYNC.
